// File: rtl/uart_word_bridge_if.sv
// Handshake bundle between uart_word_bridge and its UART Rx/Tx units and word core.
// The bridge connects through the slave modport; the environment connects through master.
interface uart_word_bridge_if #(
  parameter int BITS      = 8,
  parameter int IN_BYTES  = 2,
  parameter int RES_WIDTH = 35
);
  logic [BITS-1:0]          rx_data;
  logic                     rx_valid;
  logic                     tx_busy;
  logic                     tx_start;
  logic [BITS-1:0]          tx_data;
  logic [IN_BYTES*BITS-1:0] core_in_data;
  logic                     core_in_valid;
  logic [RES_WIDTH-1:0]     core_out_data;
  logic                     core_out_valid;
  logic                     busy;
  logic                     overrun;

  modport slave (
    input  rx_data, rx_valid, tx_busy, core_out_data, core_out_valid,
    output tx_start, tx_data, core_in_data, core_in_valid, busy, overrun
  );

  modport master (
    output rx_data, rx_valid, tx_busy, core_out_data, core_out_valid,
    input  tx_start, tx_data, core_in_data, core_in_valid, busy, overrun
  );
endinterface

// File: rtl/uart_word_bridge.sv
// Byte UART <-> word core bridge: assembles IN_BYTES bytes into a core word, then
// serialises a slice of the core result as OUT_BYTES bytes with a no-hang Tx handshake.
module uart_word_bridge #(
  parameter int BITS           = 8,
  parameter int IN_BYTES       = 2,
  parameter int OUT_BYTES      = 2,
  parameter int RES_WIDTH      = 35,
  parameter int OUT_LSB        = 19,
  parameter bit IN_MSB_FIRST   = 1'b0,
  parameter bit OUT_MSB_FIRST  = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               rst,
  uart_word_bridge_if.slave bus
);
  localparam int OUT_W   = OUT_BYTES * BITS;
  localparam int IN_CW   = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int OUT_CW  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int IDLE_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IN_CW-1:0]   IN_LAST   = IN_CW'(IN_BYTES - 1);
  localparam logic [OUT_CW-1:0]  OUT_LAST  = OUT_CW'(OUT_BYTES - 1);
  localparam logic [IDLE_CW-1:0] IDLE_LAST = IDLE_CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {COLLECT, ISSUE, WAIT_RES, SEND, TX_ACK, TX_DONE} state_t;

  state_t              state;
  logic [IN_CW-1:0]    in_cnt;
  logic [IDLE_CW-1:0]  idle_cnt;
  logic [OUT_CW-1:0]   out_cnt;
  logic [1:0]          ack_cnt;
  logic [OUT_W-1:0]    res;
  logic [IN_CW-1:0]    in_lane;
  logic [OUT_CW-1:0]   out_lane;

  // Byte order is pure lane selection; the count itself always runs upward.
  always_comb begin
    in_lane  = IN_MSB_FIRST  ? (IN_LAST - in_cnt)   : in_cnt;
    out_lane = OUT_MSB_FIRST ? (OUT_LAST - out_cnt) : out_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= COLLECT;
      in_cnt             <= '0;
      idle_cnt           <= '0;
      out_cnt            <= '0;
      ack_cnt            <= '0;
      res                <= '0;
      bus.tx_start       <= 1'b0;
      bus.tx_data        <= '0;
      bus.core_in_data   <= '0;
      bus.core_in_valid  <= 1'b0;
      bus.busy           <= 1'b0;
      bus.overrun        <= 1'b0;
    end else begin
      bus.core_in_valid <= 1'b0;
      bus.tx_start      <= 1'b0;

      if (bus.rx_valid && state != COLLECT) bus.overrun <= 1'b1;

      case (state)
        COLLECT: begin
          if (bus.rx_valid) begin
            bus.core_in_data[in_lane*BITS +: BITS] <= bus.rx_data;
            idle_cnt <= '0;
            if (in_cnt == IN_LAST) begin
              in_cnt            <= '0;
              state             <= ISSUE;
              bus.core_in_valid <= 1'b1;
              bus.busy          <= 1'b1;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end else if (in_cnt != '0) begin
            // A stalled partial word is abandoned; stale lanes get overwritten later.
            if (idle_cnt == IDLE_LAST) begin
              in_cnt   <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        ISSUE: state <= WAIT_RES;

        WAIT_RES: begin
          if (bus.core_out_valid) begin
            res     <= bus.core_out_data[OUT_LSB +: OUT_W];
            out_cnt <= '0;
            state   <= SEND;
          end
        end

        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_data  <= res[out_lane*BITS +: BITS];
            bus.tx_start <= 1'b1;
            ack_cnt      <= '0;
            state        <= TX_ACK;
          end
        end

        // Bounded wait for the transmitter to acknowledge, so a dead Tx cannot stall us.
        TX_ACK: begin
          if (bus.tx_busy || ack_cnt == 2'd3) state <= TX_DONE;
          else                                 ack_cnt <= ack_cnt + 1'b1;
        end

        TX_DONE: begin
          if (!bus.tx_busy) begin
            if (out_cnt == OUT_LAST) begin
              state    <= COLLECT;
              bus.busy <= 1'b0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
              state   <= SEND;
            end
          end
        end

        default: begin
          state    <= COLLECT;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
